// File: rtl/lutram_march_ctrl.sv
// Purpose: March C- sequencer for one single-port distributed RAM (sync write, async read).
// Latency: 10*2**A_WIDTH busy cycles fault-free; done_o rises one cycle after busy_o falls.
// Backpressure: none; start_i is ignored while busy, a start held high in DONE restarts at once.
//
// Ports: clk_i/rst_i (sync, active-high), start_i -> busy_o/done_o/pass_o status,
//        addr_o/d_o/we_o drive the RAM, q_i is its combinational read data,
//        err_cnt_o/fail_addr_o/fail_elem_o report mismatches, elem_o shows the current element.
module lutram_march_ctrl #(
    parameter int A_WIDTH      = 7,
    parameter int ERR_W        = 8,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [A_WIDTH-1:0] addr_o,
    output logic               d_o,
    output logic               we_o,
    input  logic               q_i,
    output logic [ERR_W-1:0]   err_cnt_o,
    output logic [A_WIDTH-1:0] fail_addr_o,
    output logic [2:0]         fail_elem_o,
    output logic [2:0]         elem_o
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RMW_WRITE,
        FINAL_READ,
        DONE
    } state_t;

    localparam logic [A_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [ERR_W-1:0]   ERR_MAX  = '1;

    state_t state;

    logic exp_q;
    logic descending;
    logic mismatch;
    logic last_addr;

    // Elements 2 and 4 read back ones; 1, 3 and 5 read back zeros.
    assign exp_q      = (elem_o == 3'd2) || (elem_o == 3'd4);
    assign descending = (elem_o == 3'd3) || (elem_o == 3'd4);
    assign last_addr  = descending ? (addr_o == '0) : (addr_o == ADDR_MAX);
    assign mismatch   = ((state == READ) || (state == FINAL_READ)) && (q_i != exp_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            we_o        <= 1'b0;
            d_o         <= 1'b0;
            addr_o      <= '0;
            err_cnt_o   <= '0;
            fail_addr_o <= '0;
            fail_elem_o <= '0;
            elem_o      <= '0;
        end else begin
            // Error bookkeeping; the counter never wraps back to zero, so a
            // zero count reliably identifies the first failure.
            if (mismatch) begin
                if (err_cnt_o != ERR_MAX) begin
                    err_cnt_o <= err_cnt_o + 1'b1;
                end
                if (err_cnt_o == '0) begin
                    fail_addr_o <= addr_o;
                    fail_elem_o <= elem_o;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (state == DONE) begin
                        done_o <= 1'b1;
                        pass_o <= (err_cnt_o == '0);
                    end
                    // Placed last so a restart overrides the DONE status update.
                    if (start_i) begin
                        err_cnt_o   <= '0;
                        fail_addr_o <= '0;
                        fail_elem_o <= '0;
                        done_o      <= 1'b0;
                        pass_o      <= 1'b0;
                        state       <= WRITE;
                        addr_o      <= '0;
                        we_o        <= 1'b1;
                        d_o         <= 1'b0;
                        busy_o      <= 1'b1;
                        elem_o      <= 3'd0;
                    end
                end

                WRITE: begin
                    if (addr_o == ADDR_MAX) begin
                        state  <= READ;
                        elem_o <= 3'd1;
                        addr_o <= '0;
                        we_o   <= 1'b0;
                    end else begin
                        addr_o <= addr_o + 1'b1;
                    end
                end

                READ: begin
                    if ((STOP_ON_FAIL != 0) && mismatch) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        we_o   <= 1'b0;
                    end else begin
                        state <= RMW_WRITE;
                        we_o  <= 1'b1;
                        d_o   <= ~exp_q;
                    end
                end

                RMW_WRITE: begin
                    we_o  <= 1'b0;
                    state <= READ;
                    if (last_addr) begin
                        case (elem_o)
                            3'd1: begin
                                elem_o <= 3'd2;
                                addr_o <= '0;
                            end
                            3'd2: begin
                                elem_o <= 3'd3;
                                addr_o <= ADDR_MAX;
                            end
                            3'd3: begin
                                elem_o <= 3'd4;
                                addr_o <= ADDR_MAX;
                            end
                            default: begin
                                elem_o <= 3'd5;
                                addr_o <= '0;
                                state  <= FINAL_READ;
                            end
                        endcase
                    end else if (descending) begin
                        addr_o <= addr_o - 1'b1;
                    end else begin
                        addr_o <= addr_o + 1'b1;
                    end
                end

                FINAL_READ: begin
                    if (((STOP_ON_FAIL != 0) && mismatch) || (addr_o == ADDR_MAX)) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        we_o   <= 1'b0;
                    end else begin
                        addr_o <= addr_o + 1'b1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    we_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lutram_march_ctrl.sv
// Purpose: directed bench for lutram_march_ctrl with behavioural RAM models and fault injection.
// Latency: each run is bounded by a cycle budget well above the 1280-cycle march.
// Backpressure: not applicable; the bench drives start/reset pulses only.
module tb_lutram_march_ctrl;

    localparam int AW = 7;
    localparam int EW = 8;
    localparam int N  = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    always #5 clk = ~clk;

    // Instance A: run to completion; instance B: stop on first failure.
    logic          busy_a, done_a, pass_a, d_a, we_a, q_a;
    logic [AW-1:0] addr_a, fail_addr_a;
    logic [EW-1:0] err_a;
    logic [2:0]    fail_elem_a, elem_a;

    logic          busy_b, done_b, pass_b, d_b, we_b, q_b;
    logic [AW-1:0] addr_b, fail_addr_b;
    logic [EW-1:0] err_b;
    logic [2:0]    fail_elem_b, elem_b;

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    lutram_march_ctrl #(.A_WIDTH(AW), .ERR_W(EW), .STOP_ON_FAIL(0)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a),
        .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
        .addr_o(addr_a), .d_o(d_a), .we_o(we_a), .q_i(q_a),
        .err_cnt_o(err_a), .fail_addr_o(fail_addr_a), .fail_elem_o(fail_elem_a),
        .elem_o(elem_a)
    );

    lutram_march_ctrl #(.A_WIDTH(AW), .ERR_W(EW), .STOP_ON_FAIL(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b),
        .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
        .addr_o(addr_b), .d_o(d_b), .we_o(we_b), .q_i(q_b),
        .err_cnt_o(err_b), .fail_addr_o(fail_addr_b), .fail_elem_o(fail_elem_b),
        .elem_o(elem_b)
    );

    // RAM models: synchronous write, asynchronous read, optional stuck-at cell.
    logic          mem_a [0:N-1];
    logic          mem_b [0:N-1];
    logic [1:0]    fault_mode_a = 2'd0;   // 0 none, 1 stuck-at-1, 2 stuck-at-0
    logic [AW-1:0] fault_addr_a = '0;

    always @(posedge clk) if (we_a) mem_a[addr_a] <= d_a;
    always @(posedge clk) if (we_b) mem_b[addr_b] <= d_b;

    always_comb begin
        q_a = mem_a[addr_a];
        if (fault_mode_a == 2'd1 && addr_a == fault_addr_a) q_a = 1'b1;
        if (fault_mode_a == 2'd2 && addr_a == fault_addr_a) q_a = 1'b0;
    end

    always_comb begin
        q_b = mem_b[addr_b];
        if (addr_b == 7'h05) q_b = 1'b1;
    end

    // Monotonic activity counters, sampled on the falling edge.
    int busy_tot_a = 0, wr_tot_a = 0, rd_tot_a = 0;
    int busy_tot_b = 0, wr5m1_b = 0;
    int m3_pos = 0, m3_len = 0, m3_err = 0;

    always @(negedge clk) begin
        logic [AW-1:0] exp_addr;
        if (busy_a) begin
            busy_tot_a++;
            if (we_a) wr_tot_a++;
            else      rd_tot_a++;
        end
        if (busy_a && elem_a == 3'd3) begin
            exp_addr = 7'(N - 1 - m3_pos / 2);
            if (addr_a !== exp_addr || we_a !== (m3_pos % 2 == 1)) m3_err++;
            m3_pos++;
        end else begin
            if (m3_pos != 0) m3_len = m3_pos;
            m3_pos = 0;
        end
        if (busy_b) busy_tot_b++;
        if (busy_b && we_b && addr_b == 7'h05 && elem_b == 3'd1) wr5m1_b++;
    end

    // Stimulus helper: pulse start on A and wait (bounded) for the march to end.
    task automatic run_a(input bit pulse_mid, output int nbusy, output int nwr,
                         output int nrd, output bit to, output logic done_at_fall);
        int b0, w0, r0;
        b0 = busy_tot_a; w0 = wr_tot_a; r0 = rd_tot_a;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (pulse_mid && i == 300) start_a = 1'b1;
            if (i == 301) start_a = 1'b0;
            if (!busy_a) begin
                to = 1'b0;
                break;
            end
        end
        start_a = 1'b0;
        done_at_fall = done_a;
        @(negedge clk);
        nbusy = busy_tot_a - b0;
        nwr   = wr_tot_a - w0;
        nrd   = rd_tot_a - r0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        cmp_cnt++;
        if ({busy_a, done_a, pass_a, we_a, d_a} !== 5'b0) begin
            fail_cnt++;
            $display("FAIL reset_flags: got %b, want 00000", {busy_a, done_a, pass_a, we_a, d_a});
        end
        cmp_cnt++;
        if (addr_a !== 7'h00) begin
            fail_cnt++;
            $display("FAIL reset_addr: got %h, want 00", addr_a);
        end
        cmp_cnt++;
        if (err_a !== 8'h00) begin
            fail_cnt++;
            $display("FAIL reset_err: got %h, want 00", err_a);
        end
        cmp_cnt++;
        if ({fail_addr_a, fail_elem_a, elem_a} !== 13'h0) begin
            fail_cnt++;
            $display("FAIL reset_fail_info: got %h, want 0", {fail_addr_a, fail_elem_a, elem_a});
        end
        cmp_cnt++;
        if ({busy_b, done_b, we_b} !== 3'b0) begin
            fail_cnt++;
            $display("FAIL reset_b_flags: got %b, want 000", {busy_b, done_b, we_b});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        cmp_cnt++;
        if (busy_a !== 1'b0) begin
            fail_cnt++;
            $display("FAIL idle_no_start: busy got %b, want 0", busy_a);
        end
    endtask

    task automatic test_fault_free();
        int nb, nw, nr, m3e0;
        bit to;
        logic dfall;
        fault_mode_a = 2'd0;
        m3e0 = m3_err;
        run_a(1'b1, nb, nw, nr, to, dfall);
        cmp_cnt++;
        if (to) begin fail_cnt++; $display("FAIL ff_timeout: busy never fell"); end
        cmp_cnt++;
        if (nb != 1280) begin fail_cnt++; $display("FAIL ff_busy_cycles: got %0d, want 1280", nb); end
        cmp_cnt++;
        if (nw != 640) begin fail_cnt++; $display("FAIL ff_writes: got %0d, want 640", nw); end
        cmp_cnt++;
        if (nr != 640) begin fail_cnt++; $display("FAIL ff_reads: got %0d, want 640", nr); end
        cmp_cnt++;
        if (dfall !== 1'b0) begin fail_cnt++; $display("FAIL ff_done_early: got %b, want 0", dfall); end
        cmp_cnt++;
        if ({done_a, pass_a} !== 2'b11) begin
            fail_cnt++;
            $display("FAIL ff_done_pass: got %b, want 11", {done_a, pass_a});
        end
        cmp_cnt++;
        if (err_a !== 8'h00) begin fail_cnt++; $display("FAIL ff_err: got %h, want 00", err_a); end
        cmp_cnt++;
        if (m3_err != m3e0) begin
            fail_cnt++;
            $display("FAIL m3_trace: got %0d bad steps, want 0", m3_err - m3e0);
        end
        cmp_cnt++;
        if (m3_len != 256) begin fail_cnt++; $display("FAIL m3_len: got %0d, want 256", m3_len); end
    endtask

    task automatic test_stuck1();
        int nb, nw, nr;
        bit to;
        logic dfall;
        fault_mode_a = 2'd1;
        fault_addr_a = 7'h05;
        run_a(1'b0, nb, nw, nr, to, dfall);
        cmp_cnt++;
        if (to || nb != 1280) begin
            fail_cnt++;
            $display("FAIL s1_busy: got %0d (timeout %0d), want 1280", nb, to);
        end
        cmp_cnt++;
        if ({done_a, pass_a} !== 2'b10) begin
            fail_cnt++;
            $display("FAIL s1_done_pass: got %b, want 10", {done_a, pass_a});
        end
        cmp_cnt++;
        if (err_a !== 8'd3) begin fail_cnt++; $display("FAIL s1_err: got %0d, want 3", err_a); end
        cmp_cnt++;
        if (fail_addr_a !== 7'h05) begin
            fail_cnt++;
            $display("FAIL s1_fail_addr: got %h, want 05", fail_addr_a);
        end
        cmp_cnt++;
        if (fail_elem_a !== 3'd1) begin
            fail_cnt++;
            $display("FAIL s1_fail_elem: got %0d, want 1", fail_elem_a);
        end
    endtask

    task automatic test_stuck0();
        int nb, nw, nr;
        bit to;
        logic dfall;
        fault_mode_a = 2'd2;
        fault_addr_a = 7'h7F;
        run_a(1'b0, nb, nw, nr, to, dfall);
        cmp_cnt++;
        if (to || {done_a, pass_a} !== 2'b10) begin
            fail_cnt++;
            $display("FAIL s0_done_pass: got %b (timeout %0d), want 10", {done_a, pass_a}, to);
        end
        cmp_cnt++;
        if (err_a !== 8'd2) begin fail_cnt++; $display("FAIL s0_err: got %0d, want 2", err_a); end
        cmp_cnt++;
        if (fail_addr_a !== 7'h7F) begin
            fail_cnt++;
            $display("FAIL s0_fail_addr: got %h, want 7f", fail_addr_a);
        end
        cmp_cnt++;
        if (fail_elem_a !== 3'd2) begin
            fail_cnt++;
            $display("FAIL s0_fail_elem: got %0d, want 2", fail_elem_a);
        end
        fault_mode_a = 2'd0;
    endtask

    task automatic test_stop_on_fail();
        int b0, w0;
        bit to;
        b0 = busy_tot_b; w0 = wr5m1_b;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy_b) begin to = 1'b0; break; end
        end
        @(negedge clk);
        cmp_cnt++;
        if (to || (busy_tot_b - b0) != 139) begin
            fail_cnt++;
            $display("FAIL sof_busy: got %0d (timeout %0d), want 139", busy_tot_b - b0, to);
        end
        cmp_cnt++;
        if ({done_b, pass_b} !== 2'b10) begin
            fail_cnt++;
            $display("FAIL sof_done_pass: got %b, want 10", {done_b, pass_b});
        end
        cmp_cnt++;
        if (err_b !== 8'd1) begin fail_cnt++; $display("FAIL sof_err: got %0d, want 1", err_b); end
        cmp_cnt++;
        if ({fail_addr_b, fail_elem_b} !== {7'h05, 3'd1}) begin
            fail_cnt++;
            $display("FAIL sof_fail_info: got %h/%0d, want 05/1", fail_addr_b, fail_elem_b);
        end
        cmp_cnt++;
        if (wr5m1_b != w0) begin
            fail_cnt++;
            $display("FAIL sof_write5: got %0d writes, want 0", wr5m1_b - w0);
        end
    endtask

    task automatic test_reset_mid();
        int nb, nw, nr;
        bit to, seen;
        logic dfall;
        fault_mode_a = 2'd0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (elem_a == 3'd2) begin seen = 1'b1; break; end
        end
        cmp_cnt++;
        if (!seen) begin fail_cnt++; $display("FAIL rm_reach_m2: elem 2 never seen"); end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        cmp_cnt++;
        if ({we_a, busy_a, done_a} !== 3'b000) begin
            fail_cnt++;
            $display("FAIL rm_after_reset: we/busy/done got %b, want 000", {we_a, busy_a, done_a});
        end
        rst = 1'b0;
        @(negedge clk);
        run_a(1'b0, nb, nw, nr, to, dfall);
        cmp_cnt++;
        if (to || nb != 1280) begin
            fail_cnt++;
            $display("FAIL rm_rerun_busy: got %0d (timeout %0d), want 1280", nb, to);
        end
        cmp_cnt++;
        if ({done_a, pass_a, err_a} !== {2'b11, 8'h00}) begin
            fail_cnt++;
            $display("FAIL rm_rerun_result: got %b/%0d, want 11/0", {done_a, pass_a}, err_a);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        // A sits in DONE with done_o high; a start held there restarts at once.
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        cmp_cnt++;
        if ({busy_a, done_a, we_a} !== 3'b101) begin
            fail_cnt++;
            $display("FAIL b2b_restart: busy/done/we got %b, want 101", {busy_a, done_a, we_a});
        end
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy_a) begin to = 1'b0; break; end
        end
        @(negedge clk);
        cmp_cnt++;
        if (to || {done_a, pass_a} !== 2'b11) begin
            fail_cnt++;
            $display("FAIL b2b_result: got %b (timeout %0d), want 11", {done_a, pass_a}, to);
        end
    endtask

    initial begin
        test_reset();
        test_fault_free();
        test_stuck1();
        test_stuck0();
        test_stop_on_fail();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
